// File: rtl/drim_module_top_pkg.sv
// Shared types for the DRIM simulation slice: AXI channel structs, core port
// structs, FSM state encodings and the fetch-stage branch helper.
package drim_module_top_pkg;

    localparam logic [1:0] RESP_OKAY      = 2'd0;
    localparam logic [1:0] RESP_SLVERR    = 2'd2;
    localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
    localparam logic [1:0] AXI_BURST_INCR = 2'd1;
    localparam logic [6:0] OPC_JAL        = 7'h6F;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_ax_chan_t;

    typedef struct packed {
        logic         aw_valid;
        axi_ax_chan_t aw;
        logic         w_valid;
        logic [31:0]  w_data;
        logic [3:0]   w_strb;
        logic         w_last;
        logic         b_ready;
        logic         ar_valid;
        axi_ax_chan_t ar;
        logic         r_ready;
    } axi_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        logic        b_valid;
        logic [3:0]  b_id;
        logic [1:0]  b_resp;
        logic        ar_ready;
        logic        r_valid;
        logic [3:0]  r_id;
        logic [31:0] r_data;
        logic [1:0]  r_resp;
        logic        r_last;
    } axi_resp_t;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic        err;
    } mem_resp_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } writeback_toARF;

    typedef enum logic [2:0] {
        BR_IDLE = 3'd0, BR_AR = 3'd1, BR_AWW = 3'd2, BR_R = 3'd3, BR_B = 3'd4, BR_RESP = 3'd5
    } bridge_state_e;

    typedef enum logic [2:0] {
        MS_IDLE = 3'd0, MS_AR_ACC = 3'd1, MS_R = 3'd2, MS_AW_ACC = 3'd3, MS_B = 3'd4
    } mem_state_e;

    typedef enum logic {
        CORE_REQ = 1'b0, CORE_WAIT = 1'b1
    } core_state_e;

    function automatic logic [31:0] jal_imm(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/drim_module_top_bridge.sv
// Single-outstanding bridge from a core memory port to a single-beat AXI master.
module mem_axi_bridge
    import drim_module_top_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      srst,
    input  mem_req_t  req_i,
    output logic      req_ready_o,
    output mem_resp_t resp_o,
    output axi_req_t  axi_req_o,
    input  axi_resp_t axi_resp_i
);

    bridge_state_e state_q, state_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, resp_data_q, resp_data_d;
    logic          aw_done_q, aw_done_d, w_done_q, w_done_d, resp_err_q, resp_err_d;
    logic          unused_ok_s;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BR_IDLE;  addr_q <= 32'd0;     wdata_q <= 32'd0;
            aw_done_q <= 1'b0;   w_done_q <= 1'b0;    resp_data_q <= 32'd0; resp_err_q <= 1'b0;
        end else if (srst) begin
            state_q <= BR_IDLE;  addr_q <= 32'd0;     wdata_q <= 32'd0;
            aw_done_q <= 1'b0;   w_done_q <= 1'b0;    resp_data_q <= 32'd0; resp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;  addr_q <= addr_d;    wdata_q <= wdata_d;
            aw_done_q <= aw_done_d; w_done_q <= w_done_d;
            resp_data_q <= resp_data_d; resp_err_q <= resp_err_d;
        end
    end

    // Next state; AW and W may be accepted in different cycles
    always_comb begin
        state_d = state_q;
        case (state_q)
            BR_IDLE: begin
                if (req_i.valid) state_d = req_i.we ? BR_AWW : BR_AR;
                else             state_d = BR_IDLE;
            end
            BR_AR: begin
                if (axi_resp_i.ar_ready) state_d = BR_R;
                else                     state_d = BR_AR;
            end
            BR_AWW: begin
                if ((aw_done_q || axi_resp_i.aw_ready) && (w_done_q || axi_resp_i.w_ready)) state_d = BR_B;
                else                                                                        state_d = BR_AWW;
            end
            BR_R: begin
                if (axi_resp_i.r_valid) state_d = BR_RESP;
                else                    state_d = BR_R;
            end
            BR_B: begin
                if (axi_resp_i.b_valid) state_d = BR_RESP;
                else                    state_d = BR_B;
            end
            BR_RESP: state_d = BR_IDLE;
            default: state_d = BR_IDLE;
        endcase
    end

    // Request capture, accept tracking and response capture
    always_comb begin
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        aw_done_d   = 1'b0;
        w_done_d    = 1'b0;
        if (state_q == BR_IDLE && req_i.valid) begin
            addr_d  = req_i.addr;
            wdata_d = req_i.wdata;
        end else if (state_q == BR_AWW) begin
            aw_done_d = aw_done_q || axi_resp_i.aw_ready;
            w_done_d  = w_done_q || axi_resp_i.w_ready;
        end else if (state_q == BR_R && axi_resp_i.r_valid) begin
            resp_data_d = axi_resp_i.r_data;
            resp_err_d  = (axi_resp_i.r_resp != RESP_OKAY);
        end else if (state_q == BR_B && axi_resp_i.b_valid) begin
            resp_data_d = 32'd0;
            resp_err_d  = (axi_resp_i.b_resp != RESP_OKAY);
        end else begin
            addr_d = addr_q;
        end
    end

    // Port and AXI outputs, all decoded from registered state
    always_comb begin
        req_ready_o        = (state_q == BR_IDLE);
        resp_o.valid       = (state_q == BR_RESP);
        resp_o.data        = resp_data_q;
        resp_o.err         = resp_err_q;
        axi_req_o          = '0;
        axi_req_o.ar_valid = (state_q == BR_AR);
        axi_req_o.ar.addr  = addr_q;
        axi_req_o.ar.size  = AXI_SIZE_4B;
        axi_req_o.ar.burst = AXI_BURST_INCR;
        axi_req_o.aw_valid = (state_q == BR_AWW) && !aw_done_q;
        axi_req_o.aw.addr  = addr_q;
        axi_req_o.aw.size  = AXI_SIZE_4B;
        axi_req_o.aw.burst = AXI_BURST_INCR;
        axi_req_o.w_valid  = (state_q == BR_AWW) && !w_done_q;
        axi_req_o.w_data   = wdata_q;
        axi_req_o.w_strb   = 4'hF;
        axi_req_o.w_last   = 1'b1;
        axi_req_o.b_ready  = 1'b1;
        axi_req_o.r_ready  = 1'b1;
    end

    assign unused_ok_s = ^{axi_resp_i.b_id, axi_resp_i.r_id, axi_resp_i.r_last};

endmodule

// File: rtl/drim_module_top_core.sv
// Fetch front end of the core: walks instructions on port 0, follows JAL,
// and keeps the remaining memory ports idle.
module top_processor
    import drim_module_top_pkg::*;
#(
    parameter int unsigned NoPorts = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      srst,
    output mem_req_t  [NoPorts-1:0]   req_o,
    input  logic      [NoPorts-1:0]   req_ready_i,
    input  mem_resp_t [NoPorts-1:0]   resp_i,
    output logic      [31:0]          current_pc_o
);

    core_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        unused_ok_s;

    // State and PC registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CORE_REQ;
            pc_q    <= 32'd0;
        end else if (srst) begin
            state_q <= CORE_REQ;
            pc_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state and next PC; an erroring fetch simply retries the same PC
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            CORE_REQ: begin
                if (req_ready_i[0]) state_d = CORE_WAIT;
                else                state_d = CORE_REQ;
            end
            CORE_WAIT: begin
                if (resp_i[0].valid) begin
                    state_d = CORE_REQ;
                    if (resp_i[0].err)                         pc_d = pc_q;
                    else if (resp_i[0].data[6:0] == OPC_JAL)   pc_d = pc_q + jal_imm(resp_i[0].data);
                    else                                       pc_d = pc_q + 32'd4;
                end else begin
                    state_d = CORE_WAIT;
                end
            end
            default: state_d = CORE_REQ;
        endcase
    end

    // Port requests
    always_comb begin
        req_o          = '0;
        req_o[0].valid = (state_q == CORE_REQ);
        req_o[0].addr  = pc_q;
    end

    assign current_pc_o = pc_q;
    assign unused_ok_s  = ^{resp_i, req_ready_i};

endmodule

// File: rtl/drim_module_top_mem.sv
// Simulated single-beat AXI memory: word storage plus an AXI slave FSM that
// answers SLVERR outside the implemented word range.
module sim_mem #(
    parameter int unsigned Words = 68,
    parameter int unsigned IdxW  = 7
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [IdxW-1:0] addr_i,
    input  logic [31:0]     wdata_i,
    output logic [31:0]     rdata_o
);

    logic [31:0] mem [0:Words-1];

    // Storage write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we_i) mem[addr_i] <= wdata_i;
    end

    assign rdata_o = mem[addr_i];

endmodule

module axi_sim_mem_intf
    import drim_module_top_pkg::*;
#(
    parameter int unsigned UnqAddrSpace = 68
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      srst,
    input  axi_req_t  axi_req_i,
    output axi_resp_t axi_resp_o
);

    localparam int unsigned IdxW = (UnqAddrSpace > 1) ? $clog2(UnqAddrSpace) : 1;

    mem_state_e      state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            in_range_q, in_range_d;
    logic [31:0]     wdata_q, wdata_d, rdata_q, rdata_d, rdata_s, ax_addr_s;
    logic [1:0]      resp_q, resp_d;
    logic [29:0]     ax_idx_s;
    logic            ax_in_range_s, we_s, unused_ok_s;

    assign ax_addr_s     = axi_req_i.ar_valid ? axi_req_i.ar.addr : axi_req_i.aw.addr;
    assign ax_idx_s      = ax_addr_s[31:2];
    assign ax_in_range_s = ({2'b00, ax_idx_s} < 32'(UnqAddrSpace));
    assign we_s          = (state_q == MS_AW_ACC) && axi_req_i.aw_valid && axi_req_i.w_valid && in_range_q;

    sim_mem #(.Words(UnqAddrSpace), .IdxW(IdxW)) i_sim_mem (
        .clk     (clk),
        .we_i    (we_s),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (rdata_s)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MS_IDLE; idx_q <= '0; in_range_q <= 1'b0;
            wdata_q <= 32'd0;   rdata_q <= 32'd0; resp_q <= RESP_OKAY;
        end else if (srst) begin
            state_q <= MS_IDLE; idx_q <= '0; in_range_q <= 1'b0;
            wdata_q <= 32'd0;   rdata_q <= 32'd0; resp_q <= RESP_OKAY;
        end else begin
            state_q <= state_d; idx_q <= idx_d; in_range_q <= in_range_d;
            wdata_q <= wdata_d; rdata_q <= rdata_d; resp_q <= resp_d;
        end
    end

    // Next state: READY is offered the cycle after VALID is seen
    always_comb begin
        state_d = state_q;
        case (state_q)
            MS_IDLE: begin
                if (axi_req_i.ar_valid)                           state_d = MS_AR_ACC;
                else if (axi_req_i.aw_valid && axi_req_i.w_valid) state_d = MS_AW_ACC;
                else                                              state_d = MS_IDLE;
            end
            MS_AR_ACC: state_d = axi_req_i.ar_valid ? MS_R : MS_IDLE;
            MS_R:      state_d = axi_req_i.r_ready ? MS_IDLE : MS_R;
            MS_AW_ACC: state_d = (axi_req_i.aw_valid && axi_req_i.w_valid) ? MS_B : MS_IDLE;
            MS_B:      state_d = axi_req_i.b_ready ? MS_IDLE : MS_B;
            default:   state_d = MS_IDLE;
        endcase
    end

    // Address capture in IDLE, data and response capture on acceptance
    always_comb begin
        idx_d      = idx_q;
        in_range_d = in_range_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        resp_d     = resp_q;
        if (state_q == MS_IDLE) begin
            idx_d      = ax_idx_s[IdxW-1:0];
            in_range_d = ax_in_range_s;
            wdata_d    = axi_req_i.w_data;
        end else if (state_q == MS_AR_ACC) begin
            rdata_d = in_range_q ? rdata_s : 32'd0;
            resp_d  = in_range_q ? RESP_OKAY : RESP_SLVERR;
        end else if (state_q == MS_AW_ACC) begin
            resp_d  = in_range_q ? RESP_OKAY : RESP_SLVERR;
        end else begin
            resp_d  = resp_q;
        end
    end

    // Slave channel outputs
    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.ar_ready = (state_q == MS_AR_ACC);
        axi_resp_o.aw_ready = (state_q == MS_AW_ACC);
        axi_resp_o.w_ready  = (state_q == MS_AW_ACC);
        axi_resp_o.r_valid  = (state_q == MS_R);
        axi_resp_o.r_data   = rdata_q;
        axi_resp_o.r_resp   = resp_q;
        axi_resp_o.r_last   = 1'b1;
        axi_resp_o.b_valid  = (state_q == MS_B);
        axi_resp_o.b_resp   = resp_q;
    end

    assign unused_ok_s = ^{ax_addr_s[1:0], axi_req_i.ar.id, axi_req_i.ar.len, axi_req_i.ar.size,
                           axi_req_i.ar.burst, axi_req_i.aw.id, axi_req_i.aw.len, axi_req_i.aw.size,
                           axi_req_i.aw.burst, axi_req_i.w_strb, axi_req_i.w_last};

endmodule

// File: rtl/drim_module_top.sv
// DRIM simulation top: core plus one bridge and one private AXI memory per core port.
module drim_module_top
    import drim_module_top_pkg::*;
#(
    parameter int unsigned ClkPeriod    = 10,
    parameter int unsigned NoAxiMemSims = 4,
    parameter int unsigned UnqAddrSpace = 68
) (
    input logic clk,
    input logic rst_n
);

    localparam bit DUAL_ISSUE = 1'b1;

    logic [31:0]                  current_pc;
    mem_req_t  [NoAxiMemSims-1:0] core_req_s;
    logic      [NoAxiMemSims-1:0] core_ready_s;
    mem_resp_t [NoAxiMemSims-1:0] core_resp_s;
    logic                         unused_ok_s;

    if (NoAxiMemSims < 1 || NoAxiMemSims > 8 || ClkPeriod == 0) begin : gen_bad_params
        $error("drim_module_top: NoAxiMemSims must be 1..8 and ClkPeriod nonzero");
    end

    top_processor #(.NoPorts(NoAxiMemSims)) i_top_processor (
        .clk          (clk),
        .rst_n        (rst_n),
        .srst         (1'b0),
        .req_o        (core_req_s),
        .req_ready_i  (core_ready_s),
        .resp_i       (core_resp_s),
        .current_pc_o (current_pc)
    );

    // Port i talks only to memory i; there is no crossbar between instances
    for (genvar i = 0; i < NoAxiMemSims; i++) begin : gen_axi_mem_sim
        mem_req_t  port_req_s;
        axi_req_t  axi_req_s;
        axi_resp_t axi_resp_s;

        assign port_req_s = core_req_s[i];

        mem_axi_bridge i_mem_axi_bridge (
            .clk         (clk),
            .rst_n       (rst_n),
            .srst        (1'b0),
            .req_i       (port_req_s),
            .req_ready_o (core_ready_s[i]),
            .resp_o      (core_resp_s[i]),
            .axi_req_o   (axi_req_s),
            .axi_resp_i  (axi_resp_s)
        );

        axi_sim_mem_intf #(.UnqAddrSpace(UnqAddrSpace)) i_axi_sim_mem_intf (
            .clk        (clk),
            .rst_n      (rst_n),
            .srst       (1'b0),
            .axi_req_i  (axi_req_s),
            .axi_resp_o (axi_resp_s)
        );
    end

    assign unused_ok_s = DUAL_ISSUE;

endmodule

// File: tb/tb_drim_module_top.sv
// Directed bench: preloads memories, drives ports 1..3 by force, and checks
// latency, data, error responses, reset abort and end-of-program detection.
module tb_drim_module_top;
    import drim_module_top_pkg::*;

    logic     clk;
    logic     rst_n;
    mem_req_t tb_req [1:3];
    int       n_checks;
    int       n_pass;

    drim_module_top #(.ClkPeriod(10), .NoAxiMemSims(4), .UnqAddrSpace(68)) dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [3:0] rv_vec();
        return {dut.core_resp_s[3].valid, dut.core_resp_s[2].valid,
                dut.core_resp_s[1].valid, dut.core_resp_s[0].valid};
    endfunction

    function automatic logic [3:0] err_vec();
        return {dut.core_resp_s[3].err, dut.core_resp_s[2].err,
                dut.core_resp_s[1].err, dut.core_resp_s[0].err};
    endfunction

    // One transaction on forced port p; response expected in cycle t+4
    task automatic port_txn(input int p, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_data,
                            input logic exp_err, input string tag);
        int lat;
        @(negedge clk);
        check_eq({tag, "_ready"}, 32'(dut.core_ready_s[p]), 32'd1);
        tb_req[p] = '{valid: 1'b1, we: we, addr: addr, wdata: wdata};
        @(negedge clk);
        tb_req[p].valid = 1'b0;
        lat = 1;
        while (!dut.core_resp_s[p].valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'd4);
        if (!we) check_eq({tag, "_data"}, dut.core_resp_s[p].data, exp_data);
        check_eq({tag, "_err"}, 32'(dut.core_resp_s[p].err), 32'(exp_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        for (int p = 1; p <= 3; p++) tb_req[p] = '0;
        force dut.gen_axi_mem_sim[1].port_req_s = tb_req[1];
        force dut.gen_axi_mem_sim[2].port_req_s = tb_req[2];
        force dut.gen_axi_mem_sim[3].port_req_s = tb_req[3];

        // Program: NOPs up to 0x3C (word 4 is a different NOP), self-branch at 0x40
        for (int w = 0; w < 16; w++) dut.gen_axi_mem_sim[0].i_axi_sim_mem_intf.i_sim_mem.mem[w] = 32'h0000_0013;
        dut.gen_axi_mem_sim[0].i_axi_sim_mem_intf.i_sim_mem.mem[4]  = 32'h0010_0013;
        dut.gen_axi_mem_sim[0].i_axi_sim_mem_intf.i_sim_mem.mem[16] = 32'h0000_006F;
        dut.gen_axi_mem_sim[1].i_axi_sim_mem_intf.i_sim_mem.mem[0]  = 32'h0000_0013;
        dut.gen_axi_mem_sim[2].i_axi_sim_mem_intf.i_sim_mem.mem[0]  = 32'h0000_0013;
        dut.gen_axi_mem_sim[3].i_axi_sim_mem_intf.i_sim_mem.mem[0]  = 32'h0000_0013;
        dut.gen_axi_mem_sim[1].i_axi_sim_mem_intf.i_sim_mem.mem[1]  = 32'h0000_00A1;
        dut.gen_axi_mem_sim[2].i_axi_sim_mem_intf.i_sim_mem.mem[1]  = 32'h0000_00A2;
        dut.gen_axi_mem_sim[3].i_axi_sim_mem_intf.i_sim_mem.mem[1]  = 32'h0000_00A3;
        dut.gen_axi_mem_sim[1].i_axi_sim_mem_intf.i_sim_mem.mem[4]  = 32'h1111_1111;

        repeat (3) @(negedge clk);
        check_eq("rst_pc", dut.current_pc, 32'h0);
        check_eq("rst_resp_valid", 32'(rv_vec()), 32'h0);

        // All four ports handshake on the first edge after reset release
        for (int p = 1; p <= 3; p++) tb_req[p] = '{valid: 1'b1, we: 1'b0, addr: 32'h4, wdata: 32'h0};
        rst_n = 1'b1;
        @(negedge clk);
        for (int p = 1; p <= 3; p++) tb_req[p].valid = 1'b0;
        check_eq("sim_rv_t1", 32'(rv_vec()), 32'h0);
        @(negedge clk);
        check_eq("sim_rv_t2", 32'(rv_vec()), 32'h0);
        @(negedge clk);
        check_eq("sim_rv_t3", 32'(rv_vec()), 32'h0);
        @(negedge clk);
        check_eq("sim_rv_t4", 32'(rv_vec()), 32'hF);
        check_eq("sim_data0", dut.core_resp_s[0].data, 32'h0000_0013);
        check_eq("sim_data1", dut.core_resp_s[1].data, 32'h0000_00A1);
        check_eq("sim_data2", dut.core_resp_s[2].data, 32'h0000_00A2);
        check_eq("sim_data3", dut.core_resp_s[3].data, 32'h0000_00A3);
        check_eq("sim_err", 32'(err_vec()), 32'h0);
        @(negedge clk);
        check_eq("sim_rv_t5", 32'(rv_vec()), 32'h0);

        port_txn(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, "p1_wr");
        check_eq("p1_mem4", dut.gen_axi_mem_sim[1].i_axi_sim_mem_intf.i_sim_mem.mem[4], 32'hDEAD_BEEF);
        check_eq("p0_mem4", dut.gen_axi_mem_sim[0].i_axi_sim_mem_intf.i_sim_mem.mem[4], 32'h0010_0013);
        port_txn(1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, "p1_rd");
        port_txn(1, 1'b0, 32'h13, 32'h0, 32'hDEAD_BEEF, 1'b0, "p1_rd_lowbits");
        port_txn(2, 1'b0, 32'h10C, 32'h0, 32'h0, 1'b0, "p2_rd_last");
        port_txn(2, 1'b0, 32'h110, 32'h0, 32'h0, 1'b1, "p2_rd_oob");
        port_txn(2, 1'b1, 32'h110, 32'h5555_AAAA, 32'h0, 1'b1, "p2_wr_oob");
        check_eq("p2_mem0", dut.gen_axi_mem_sim[2].i_axi_sim_mem_intf.i_sim_mem.mem[0], 32'h0000_0013);
        check_eq("p2_mem1", dut.gen_axi_mem_sim[2].i_axi_sim_mem_intf.i_sim_mem.mem[1], 32'h0000_00A2);

        // Reset while port 3 waits for R: no response may appear
        @(negedge clk);
        tb_req[3] = '{valid: 1'b1, we: 1'b0, addr: 32'h4, wdata: 32'h0};
        @(negedge clk);
        tb_req[3].valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("p3_in_r", 32'(dut.gen_axi_mem_sim[3].i_mem_axi_bridge.state_q), 32'(BR_R));
        rst_n = 1'b0;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (dut.core_resp_s[3].valid) n++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (dut.core_resp_s[3].valid) n++;
        end
        check_eq("p3_rst_noresp", 32'(n), 32'd0);
        port_txn(3, 1'b0, 32'h4, 32'h0, 32'h0000_00A3, 1'b0, "p3_after_rst");

        n = 0;
        while (dut.current_pc != 32'h40 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("pc_reach", dut.current_pc, 32'h40);
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (dut.current_pc != 32'h40) bad++;
        end
        check_eq("pc_hold", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/drim_module_top.md
# drim_module_top

Top-level integration block of the DRIM simulation system. It instantiates the out-of-order RISC core (`top_processor`) and `NoAxiMemSims` independent simulated AXI memories, and bridges each core memory port to its memory through a per-port request-to-AXI bridge. The block has no functional I/O beyond clock and reset. Benches observe it hierarchically: they preload the memories and watch the fetch PC to detect end of program.

## Interface
- `ClkPeriod`, default 10ns: clock period. Sets memory input application delay to ClkPeriod/4 and output acquisition delay to 3·ClkPeriod/4 (simulation only).
- `NoAxiMemSims`, default 4: number of core memory ports and AXI memory instances, 1..8.
- `UnqAddrSpace`, default 68: number of 32-bit words per memory instance.
- `clk`  in  1  system clock. One clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- Hierarchically visible, names fixed:
  - `DUAL_ISSUE`: localparam bit, value 1.
  - `current_pc`: 32-bit fetch PC of `top_processor`.
  - `gen_axi_mem_sim[i].i_axi_sim_mem_intf.i_sim_mem.mem`: word array `[0:UnqAddrSpace-1]` of 32 bits.

## Operation
- Core port i (0..NoAxiMemSims-1) has these signals:
  - request: `req_valid`, `req_ready`, `req_we`, `req_addr[31:0]`, `req_wdata[31:0]`
  - response: `resp_valid`, `resp_data[31:0]`, `resp_err`
- Port i connects only to bridge i, and bridge i connects only to memory i. There is no crossbar and no coherence between instances.
- Bridge FSM states:
  - IDLE: `req_ready`=1. A handshake moves to AR if `req_we`=0, or to AWW if `req_we`=1.
  - AR: drive ARVALID until ARREADY, then go to R.
  - AWW: drive AWVALID and WVALID together. Track each accept separately; go to B when both are done.
  - R / B: wait for RVALID / BVALID (RREADY and BREADY held at 1), then go to RESP.
  - RESP: one cycle with `resp_valid`=1, then back to IDLE.
- The bridge accepts no new request outside IDLE.
- AXI signals: single-beat, 32-bit, size 4, id 0, INCR.
- Memory word index = addr[31:2]; addr[1:0] is ignored.
- If index ≥ UnqAddrSpace:
  - read: returns data 0 with SLVERR.
  - write: ignored, returns SLVERR.
  - `resp_err` = (RESP ≠ OKAY).
- Writes update the array in the cycle BVALID is asserted.
- Memories accept AR and AW one cycle after valid, i.e. READY in the following cycle.
- `current_pc` is driven directly from the core fetch stage.

## Timing
- Reset values: bridges in IDLE, all valids 0, `resp_data` 0, `resp_err` 0, `current_pc` 0, memory FSMs idle.
- Memory arrays are not cleared by reset. The bench preloads them at time 0, before reset.
- Read latency is 4 cycles from request handshake (cycle t):
  - t+1 AR valid
  - t+2 AR accepted
  - t+3 R valid
  - t+4 `resp_valid`
- Write latency is 4 cycles, with the same shape through AW/W and B.
- The earliest next request handshake on a port is the cycle after RESP.
- Reset asserted mid-transaction: all FSMs return to IDLE asynchronously. No response is issued, and a pending write is dropped unless B was already asserted.
- Ports are fully independent, so simultaneous requests on all ports complete in the same cycle.

## Structure
- Shared package (`structs.sv`) holds:
  - AXI req/resp structs
  - the `writeback_toARF` type
  - `mem_req_t` / `mem_resp_t` for core ports
  - RESP encodings OKAY=0, SLVERR=2
- Sub-module `axi_sim_mem_intf` contains the storage instance `i_sim_mem` (array `mem`) and the AXI slave FSM. It is instantiated in generate block `gen_axi_mem_sim`.
- The bridge is a second small module, `mem_axi_bridge`, one per port.
- `top_processor` is an existing block, instantiated unchanged.

## Test plan
- Preload mem[0]=0x00000013 in all instances, assert reset → `current_pc`=0 and all `resp_valid`=0. After release, the port-0 read of addr 0 returns 0x00000013 with `resp_err`=0, exactly 4 cycles after the handshake.
- Port 1: write 0xDEADBEEF to addr 0x10, then read 0x10 → 0xDEADBEEF. A port-0 read of 0x10 still returns the preloaded value.
- Read addr 4·68=0x110 → `resp_data`=0, `resp_err`=1. Write to 0x110 → `resp_err`=1 and no array change.
- Requests on ports 0..3 in the same cycle → all four `resp_valid` rise in the same cycle, each with its own data.
- Deassert `rst_n` during the R wait state → no `resp_valid` occurs. After release, a new request completes normally.
- Program ending in a self-branch at 0x40 → `current_pc` holds 0x40 for ≥500 cycles.
